// File: rtl/fg_pkg.sv
// Shared types and default widths for the sample-to-PWM modulator.
// Dithering of the duty cycle is enabled by defining PWM_DITHER_EN.
package fg_pkg;

    localparam int DEFAULT_IN_W  = 16;
    localparam int DEFAULT_CNT_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN
    } pwm_state_t;

endpackage

// File: rtl/pwm_sample_buffer.sv
// One-entry holding buffer between the generator sum stage and the PWM core.
// New samples are refused while the entry is occupied; the core empties it on a duty load.
module pwm_sample_buffer
    import fg_pkg::*;
#(
    parameter int IN_W = DEFAULT_IN_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IN_W-1:0] sample_in,
    input  logic            sample_valid,
    input  logic            consume,
    output logic            sample_ready,
    output logic [IN_W-1:0] buf_data,
    output logic            buf_full
);

    assign sample_ready = !buf_full;

    // A write and a consume can never coincide because writes need an empty entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_data <= '0;
            buf_full <= 1'b0;
        end else if (sample_valid && !buf_full) begin
            buf_data <= sample_in;
            buf_full <= 1'b1;
        end else if (consume) begin
            buf_full <= 1'b0;
        end
    end

endmodule

// File: rtl/sample_pwm_modulator.sv
// Converts a stream of unsigned samples into a PWM waveform, one sample per period.
// Define PWM_DITHER_EN to carry the truncated fraction forward into later duty values.
module sample_pwm_modulator
    import fg_pkg::*;
#(
    parameter int IN_W  = DEFAULT_IN_W,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [IN_W-1:0] sample_in,
    input  logic            sample_valid,
    output logic            sample_ready,
    output logic            pwm,
    output logic            period_start,
    output logic            underrun
);

    localparam int FRAC_W = IN_W - CNT_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    pwm_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] duty;
    logic [CNT_W-1:0] duty_next;
    logic [CNT_W-1:0] trunc_duty;
    logic [IN_W-1:0]  buf_data;
    logic             buf_full;
    logic             at_wrap;
    logic             consume;

    pwm_sample_buffer #(
        .IN_W(IN_W)
    ) u_buffer (
        .clk         (clk),
        .reset       (reset),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .consume     (consume),
        .sample_ready(sample_ready),
        .buf_data    (buf_data),
        .buf_full    (buf_full)
    );

    assign trunc_duty = buf_data[IN_W-1 -: CNT_W];
    assign at_wrap    = (cnt == CNT_MAX);
    assign consume    = enable && buf_full &&
                        ((state == ARM) || ((state == RUN) && at_wrap));

`ifdef PWM_DITHER_EN
    logic [FRAC_W-1:0] err;
    logic [FRAC_W:0]   err_sum;

    assign err_sum   = {1'b0, err} + {1'b0, buf_data[FRAC_W-1:0]};
    assign duty_next = (err_sum[FRAC_W] && (trunc_duty != CNT_MAX)) ?
                       trunc_duty + CNT_ONE : trunc_duty;

    // The fraction accumulator only advances when a duty value is actually taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= '0;
        end else if (consume) begin
            err <= err_sum[FRAC_W-1:0];
        end
    end
`else
    logic unused_frac;

    assign unused_frac = ^buf_data[FRAC_W-1:0];
    assign duty_next   = trunc_duty;
`endif

    // pwm lags cnt by one cycle; the duty swap happens on the same edge cnt wraps to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            duty         <= '0;
            pwm          <= 1'b0;
            period_start <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            period_start <= 1'b0;
            underrun     <= 1'b0;
            if (!enable) begin
                state <= IDLE;
                cnt   <= '0;
                pwm   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt   <= '0;
                        pwm   <= 1'b0;
                        state <= ARM;
                    end
                    ARM: begin
                        cnt <= '0;
                        pwm <= 1'b0;
                        if (buf_full) begin
                            duty         <= duty_next;
                            state        <= RUN;
                            period_start <= 1'b1;
                        end
                    end
                    RUN: begin
                        pwm <= (cnt < duty);
                        cnt <= cnt + CNT_ONE;
                        if (at_wrap) begin
                            period_start <= 1'b1;
                            if (buf_full) begin
                                duty <= duty_next;
                            end else begin
                                underrun <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                        pwm   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
